// File: rtl/modbus_pkg.sv
// Shared definitions for the Modbus RTU serial transmitter.
// Build option: MODBUS_TX_PARITY_EN (see modbus_uart_tx.sv).
`timescale 1ns/1ps
package modbus_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int BITS_PER_CHAR  = 11;  // start + 8 data + (parity + 1 stop | 2 stop)
  localparam int GAP_BITS_DEF   = 39;  // 3.5 chars x 11 bits, rounded up

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP,
    TX_GAP
  } tx_state_e;
endpackage

// File: rtl/modbus_baud_tick.sv
// Bit-period divider: bit_end_o pulses on the last clk cycle of every bit.
// restart_i realigns the period so a new character starts on the pop edge.
`timescale 1ns/1ps
module modbus_baud_tick #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic bit_end_o
);
  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: wrap at the end of a bit, or restart at a character start
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || cnt_q == LAST) cnt_d = '0;
  end

  // bit timer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bit_end_o = (cnt_q == LAST);
endmodule

// File: rtl/modbus_uart_tx.sv
// Modbus RTU UART transmitter: drains a show-ahead FIFO, sends 8N2 (or 8E1)
// characters LSB first, and closes each frame with a 3.5-character idle gap.
// Build option: MODBUS_TX_PARITY_EN -> even parity bit + 1 stop bit;
// undefined -> no parity + 2 stop bits. Both are 11 bit-times per character.
`timescale 1ns/1ps
module modbus_uart_tx
  import modbus_pkg::*;
#(
  parameter int CLK_DIV  = 16,
  parameter int GAP_BITS = GAP_BITS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fifoEmpty,
  input  logic [UART_DATA_BITS-1:0] fifoData,
  output logic                      fifoReadReq,
  output logic                      txd,
  output logic                      busy,
  output logic                      frameDone
);
  localparam int GAP_CYC = GAP_BITS * CLK_DIV;
  localparam int GW      = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);
  localparam logic [2:0]    DATA_LAST = 3'(UART_DATA_BITS - 1);
`ifdef MODBUS_TX_PARITY_EN
  localparam logic [2:0]    STOP_LAST = 3'd0;
`else
  localparam logic [2:0]    STOP_LAST = 3'd1;
`endif

  tx_state_e                 state_q, state_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic [2:0]                bcnt_q, bcnt_d;
  logic [GW-1:0]             gcnt_q, gcnt_d;
  logic                      txd_q, txd_d;
  logic                      pop_q, pop_d;
  logic                      done_q, done_d;
  logic                      bit_end;

  modbus_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .restart_i (pop_d),
    .bit_end_o (bit_end)
  );

  // next-state, counters, and registered line/strobe values
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    bcnt_d  = bcnt_q;
    gcnt_d  = gcnt_q;
    pop_d   = 1'b0;
    txd_d   = 1'b1;
    done_d  = 1'b0;

    unique case (state_q)
      TX_IDLE: if (!fifoEmpty) pop_d = 1'b1;
      TX_START: if (bit_end) begin
        state_d = TX_DATA;
        bcnt_d  = '0;
      end
      TX_DATA: if (bit_end) begin
        if (bcnt_q == DATA_LAST) begin
`ifdef MODBUS_TX_PARITY_EN
          state_d = TX_PARITY;
`else
          state_d = TX_STOP;
`endif
          bcnt_d = '0;
        end else begin
          bcnt_d = bcnt_q + 3'd1;
        end
      end
      TX_PARITY: if (bit_end) begin
        state_d = TX_STOP;
        bcnt_d  = '0;
      end
      TX_STOP: if (bit_end) begin
        if (bcnt_q == STOP_LAST) begin
          // back-to-back character if more bytes are waiting
          if (!fifoEmpty) begin
            pop_d = 1'b1;
          end else begin
            state_d = TX_GAP;
            gcnt_d  = '0;
          end
        end else begin
          bcnt_d = bcnt_q + 3'd1;
        end
      end
      TX_GAP: begin
        // the FIFO is deliberately ignored here
        if (gcnt_q == GAP_LAST) begin
          state_d = TX_IDLE;
          gcnt_d  = '0;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    if (pop_d) begin
      state_d = TX_START;
      data_d  = fifoData;
      bcnt_d  = '0;
    end

    unique case (state_d)
      TX_START:  txd_d = 1'b0;
      TX_DATA:   txd_d = data_d[bcnt_d];
      TX_PARITY: txd_d = ^data_d;
      default:   txd_d = 1'b1;
    endcase

    done_d = (state_d == TX_GAP) && (gcnt_d == GAP_LAST);
  end

  // state and output registers; reset drops the line high immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      data_q  <= '0;
      bcnt_q  <= '0;
      gcnt_q  <= '0;
      txd_q   <= 1'b1;
      pop_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      bcnt_q  <= bcnt_d;
      gcnt_q  <= gcnt_d;
      txd_q   <= txd_d;
      pop_q   <= pop_d;
      done_q  <= done_d;
    end
  end

  assign txd         = txd_q;
  assign fifoReadReq = pop_q;
  assign frameDone   = done_q;
  assign busy        = (state_q != TX_IDLE);
endmodule
